// File: rtl/sap_ram_pkg.sv
// rtl/sap_ram_pkg.sv - shared state encoding and mode constants for the synchronous SAP RAM
package sap_ram_pkg;

  typedef enum logic [1:0] {
    CLEAR,
    RUN,
    PROGRAM
  } ram_state_t;

  localparam logic MODE_RUN     = 1'b0;
  localparam logic MODE_PROGRAM = 1'b1;

endpackage

// File: rtl/ram_sync_if.sv
// rtl/ram_sync_if.sv - W-bus access port of the synchronous SAP RAM
interface ram_sync_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0] i_address;
  logic                  i_write_enable;
  logic                  i_read_enable;
  logic [DATA_WIDTH-1:0] i_data;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_data_valid;
  logic                  o_drive;

  modport master (
    output i_address, i_write_enable, i_read_enable, i_data,
    input  o_data, o_data_valid, o_drive
  );

  modport slave (
    input  i_address, i_write_enable, i_read_enable, i_data,
    output o_data, o_data_valid, o_drive
  );
endinterface

// File: rtl/sap_edge_detect.sv
// rtl/sap_edge_detect.sv - registered rising-edge detector for front-panel buttons
// History resets to 1 so a button held through reset never produces an edge.
module sap_edge_detect (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic rise_o
);

  logic hist_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hist_q <= 1'b1;
    end else begin
      hist_q <= d_i;
    end
  end

  assign rise_o = d_i & ~hist_q;

endmodule

// File: rtl/ram_sync.sv
// rtl/ram_sync.sv - clocked SAP RAM with run-mode bus access, manual loader and zero-fill after reset
// Optional per-word even parity enabled by defining RAM_SYNC_PARITY_EN.
module ram_sync
  import sap_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  ram_sync_if.slave             bus,
  input  logic                  i_program_mode,
  input  logic [DATA_WIDTH-1:0] i_program_data,
  input  logic                  i_program_strobe,
  input  logic                  i_program_load,
  output logic [ADDR_WIDTH-1:0] o_program_address,
  output logic                  o_busy,
  output logic                  o_parity_error
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
`ifdef RAM_SYNC_PARITY_EN
  localparam int MEM_W = DATA_WIDTH + 1;
`else
  localparam int MEM_W = DATA_WIDTH;
`endif

  function automatic logic [MEM_W-1:0] encode(input logic [DATA_WIDTH-1:0] d);
`ifdef RAM_SYNC_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  logic [MEM_W-1:0]      mem_q [DEPTH];
  ram_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  perr_q, perr_d;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [MEM_W-1:0]      mem_wdata;
  logic [MEM_W-1:0]      rd_word;
  logic                  strobe_rise;

  sap_edge_detect u_strobe_edge (
    .clk_i   (i_clk),
    .reset_i (i_reset),
    .d_i     (i_program_strobe),
    .rise_o  (strobe_rise)
  );

  assign rd_word = mem_q[bus.i_address];

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ptr_d     = ptr_q;
    rdata_d   = rdata_q;
    valid_d   = 1'b0;
    busy_d    = busy_q;
    perr_d    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = clr_cnt_q;
    mem_wdata = '0;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
          busy_d  = 1'b0;
          state_d = (i_program_mode == MODE_PROGRAM) ? PROGRAM : RUN;
        end
      end
      RUN: begin
        // A write in the same cycle as a read wins and suppresses the response.
        if (bus.i_write_enable) begin
          mem_we    = 1'b1;
          mem_waddr = bus.i_address;
          mem_wdata = encode(bus.i_data);
        end else if (bus.i_read_enable) begin
          rdata_d = rd_word[DATA_WIDTH-1:0];
          valid_d = 1'b1;
`ifdef RAM_SYNC_PARITY_EN
          perr_d  = (^rd_word[DATA_WIDTH-1:0]) != rd_word[DATA_WIDTH];
`endif
        end
        if (i_program_mode == MODE_PROGRAM) begin
          state_d = PROGRAM;
        end
      end
      PROGRAM: begin
        if (i_program_load) begin
          ptr_d = bus.i_address;
        end else if (strobe_rise) begin
          mem_we    = 1'b1;
          mem_waddr = ptr_q;
          mem_wdata = encode(i_program_data);
          ptr_d     = ptr_q + 1'b1;
        end
        if (i_program_mode == MODE_RUN) begin
          state_d = RUN;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      ptr_q     <= '0;
      rdata_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b1;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ptr_q     <= ptr_d;
      rdata_q   <= rdata_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      perr_q    <= perr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_we && !i_reset) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.o_data        = rdata_q;
  assign bus.o_data_valid  = valid_q;
  assign bus.o_drive       = valid_q;
  assign o_program_address = ptr_q;
  assign o_busy            = busy_q;
  assign o_parity_error    = perr_q;

endmodule

// File: tb/tb_ram_sync.sv
// tb/tb_ram_sync.sv - self-checking bench for ram_sync with a read-data scoreboard
module tb_ram_sync;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          prog_mode;
  logic [DW-1:0] prog_data;
  logic          prog_strobe;
  logic          prog_load;
  logic [AW-1:0] prog_addr;
  logic          busy;
  logic          perr;

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] exp_q [$];
  int            pass_cnt = 0;
  int            total_cnt = 0;

  ram_sync_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram_sync #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clk             (clk),
    .i_reset           (rst),
    .bus               (bus),
    .i_program_mode    (prog_mode),
    .i_program_data    (prog_data),
    .i_program_strobe  (prog_strobe),
    .i_program_load    (prog_load),
    .o_program_address (prog_addr),
    .o_busy            (busy),
    .o_parity_error    (perr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic test_reset();
    int n;
    apply_reset();
    total_cnt++; if (bus.o_data !== 8'h00) $display("FAIL reset_data: got %h want 00", bus.o_data); else pass_cnt++;
    total_cnt++; if (bus.o_data_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.o_data_valid); else pass_cnt++;
    total_cnt++; if (bus.o_drive !== 1'b0) $display("FAIL reset_drive: got %b want 0", bus.o_drive); else pass_cnt++;
    total_cnt++; if (perr !== 1'b0) $display("FAIL reset_perr: got %b want 0", perr); else pass_cnt++;
    total_cnt++; if (prog_addr !== 4'd0) $display("FAIL reset_ptr: got %0d want 0", prog_addr); else pass_cnt++;
    count_busy(n);
    total_cnt++; if (n !== 16) $display("FAIL reset_busy_cycles: got %0d want 16", n); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy_end: got %b want 0", busy); else pass_cnt++;
    clear_model();
  endtask

  task automatic test_readback_all();
    logic [DW-1:0] exp;
    bus.i_write_enable = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      if (i > 0) begin
        total_cnt++; if (bus.o_data_valid !== 1'b1) $display("FAIL rb_valid[%0d]: got %b want 1", i - 1, bus.o_data_valid); else pass_cnt++;
        exp = exp_q.pop_front();
        total_cnt++; if (bus.o_data !== exp) $display("FAIL rb_data[%0d]: got %h want %h", i - 1, bus.o_data, exp); else pass_cnt++;
        total_cnt++; if (perr !== 1'b0) $display("FAIL rb_perr[%0d]: got %b want 0", i - 1, perr); else pass_cnt++;
      end
      if (i < DEPTH) begin
        bus.i_address     = AW'(i);
        bus.i_read_enable = 1'b1;
        exp_q.push_back(model[i]);
      end else begin
        bus.i_read_enable = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_run();
    logic [DW-1:0] exp;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bus.i_write_enable = 1'b1; bus.i_read_enable = 1'b0;
    bus.i_address = 4'd3; bus.i_data = 8'hA5; model[3] = 8'hA5;
    @(negedge clk);
    bus.i_write_enable = 1'b0;
    total_cnt++; if (bus.o_data_valid !== 1'b0) $display("FAIL run_write_novalid: got %b want 0", bus.o_data_valid); else pass_cnt++;
    bus.i_read_enable = 1'b1; exp_q.push_back(model[3]);
    @(negedge clk);
    bus.i_read_enable = 1'b0;
    total_cnt++; if (bus.o_data_valid !== 1'b1) $display("FAIL run_rd_valid: got %b want 1", bus.o_data_valid); else pass_cnt++;
    total_cnt++; if (bus.o_drive !== 1'b1) $display("FAIL run_rd_drive: got %b want 1", bus.o_drive); else pass_cnt++;
    exp = exp_q.pop_front();
    total_cnt++; if (bus.o_data !== exp) $display("FAIL run_rd_data: got %h want %h", bus.o_data, exp); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (bus.o_data_valid !== 1'b0) $display("FAIL run_idle_valid: got %b want 0", bus.o_data_valid); else pass_cnt++;
    total_cnt++; if (bus.o_drive !== 1'b0) $display("FAIL run_idle_drive: got %b want 0", bus.o_drive); else pass_cnt++;
    total_cnt++; if (bus.o_data !== 8'hA5) $display("FAIL run_idle_hold: got %h want a5", bus.o_data); else pass_cnt++;
    bus.i_write_enable = 1'b1; bus.i_read_enable = 1'b1; bus.i_data = 8'h5A; model[3] = 8'h5A;
    @(negedge clk);
    bus.i_write_enable = 1'b0; bus.i_read_enable = 1'b0;
    total_cnt++; if (bus.o_data_valid !== 1'b0) $display("FAIL run_wr_rd_same: got %b want 0", bus.o_data_valid); else pass_cnt++;
    for (int k = 0; k < 6; k++) begin
      a = AW'($urandom_range(0, DEPTH - 1));
      d = DW'($urandom);
      bus.i_write_enable = 1'b1; bus.i_address = a; bus.i_data = d; model[a] = d;
      @(negedge clk);
    end
    bus.i_write_enable = 1'b0;
  endtask

  task automatic test_program();
    logic [DW-1:0] pd [3];
    pd[0] = 8'h11; pd[1] = 8'h22; pd[2] = 8'h33;
    prog_mode = 1'b1;
    @(negedge clk);
    prog_load = 1'b1; bus.i_address = 4'd14;
    @(negedge clk);
    prog_load = 1'b0;
    total_cnt++; if (prog_addr !== 4'd14) $display("FAIL prog_load: got %0d want 14", prog_addr); else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      prog_data = pd[k]; prog_strobe = 1'b1;
      @(negedge clk);
      prog_strobe = 1'b0;
      @(negedge clk);
      model[(14 + k) % DEPTH] = pd[k];
    end
    total_cnt++; if (prog_addr !== 4'd1) $display("FAIL prog_ptr_wrap: got %0d want 1", prog_addr); else pass_cnt++;
    prog_data = 8'h44; prog_strobe = 1'b1;
    repeat (5) @(negedge clk);
    prog_strobe = 1'b0; model[1] = 8'h44;
    @(negedge clk);
    total_cnt++; if (prog_addr !== 4'd2) $display("FAIL prog_held_strobe: got %0d want 2", prog_addr); else pass_cnt++;
    prog_load = 1'b1; bus.i_address = 4'd8; prog_strobe = 1'b1; prog_data = 8'h99;
    @(negedge clk);
    prog_load = 1'b0; prog_strobe = 1'b0;
    total_cnt++; if (prog_addr !== 4'd8) $display("FAIL prog_load_priority: got %0d want 8", prog_addr); else pass_cnt++;
    bus.i_address = 4'd3; bus.i_read_enable = 1'b1;
    @(negedge clk);
    bus.i_read_enable = 1'b0;
    total_cnt++; if (bus.o_data_valid !== 1'b0) $display("FAIL prog_bus_ignored: got %b want 0", bus.o_data_valid); else pass_cnt++;
    prog_mode = 1'b0;
    @(negedge clk);
    total_cnt++; if (prog_addr !== 4'd8) $display("FAIL prog_ptr_retained: got %0d want 8", prog_addr); else pass_cnt++;
  endtask

  task automatic test_strobe_through_reset();
    int n;
    prog_strobe = 1'b1; prog_mode = 1'b1; prog_data = 8'hC3;
    apply_reset();
    count_busy(n);
    total_cnt++; if (n !== 16) $display("FAIL str_busy_cycles: got %0d want 16", n); else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++; if (prog_addr !== 4'd0) $display("FAIL str_held_no_write: got %0d want 0", prog_addr); else pass_cnt++;
    prog_strobe = 1'b0; prog_mode = 1'b0;
    @(negedge clk);
    clear_model();
  endtask

  task automatic test_reset_mid();
    int n;
    for (int i = 0; i < DEPTH; i++) begin
      bus.i_write_enable = 1'b1; bus.i_address = AW'(i); bus.i_data = DW'(i + 8'h80);
      @(negedge clk);
    end
    bus.i_write_enable = 1'b0; prog_mode = 1'b1;
    repeat (2) @(negedge clk);
    prog_data = 8'h77; prog_strobe = 1'b1;
    @(negedge clk);
    prog_strobe = 1'b0;
    @(negedge clk);
    total_cnt++; if (prog_addr !== 4'd1) $display("FAIL mid_prog_ptr: got %0d want 1", prog_addr); else pass_cnt++;
    apply_reset();
    prog_mode = 1'b0;
    bus.i_write_enable = 1'b1; bus.i_address = 4'd2; bus.i_data = 8'hFF;
    repeat (5) @(negedge clk);
    total_cnt++; if (busy !== 1'b1) $display("FAIL mid_clear_busy: got %b want 1", busy); else pass_cnt++;
    apply_reset();
    count_busy(n);
    bus.i_write_enable = 1'b0;
    total_cnt++; if (n !== 16) $display("FAIL mid_restart_cycles: got %0d want 16", n); else pass_cnt++;
    total_cnt++; if (prog_addr !== 4'd0) $display("FAIL mid_ptr_reset: got %0d want 0", prog_addr); else pass_cnt++;
    clear_model();
  endtask

`ifdef RAM_SYNC_PARITY_EN
  task automatic test_parity();
    bus.i_write_enable = 1'b1; bus.i_address = 4'd5; bus.i_data = 8'h37;
    @(negedge clk);
    bus.i_write_enable = 1'b0; bus.i_read_enable = 1'b1;
    @(negedge clk);
    bus.i_read_enable = 1'b0;
    total_cnt++; if (bus.o_data_valid !== 1'b1) $display("FAIL par_ok_valid: got %b want 1", bus.o_data_valid); else pass_cnt++;
    total_cnt++; if (perr !== 1'b0) $display("FAIL par_ok_perr: got %b want 0", perr); else pass_cnt++;
    dut.mem_q[5] = dut.mem_q[5] ^ 9'h001;
    bus.i_read_enable = 1'b1;
    @(negedge clk);
    bus.i_read_enable = 1'b0;
    total_cnt++; if (bus.o_data_valid !== 1'b1) $display("FAIL par_bad_valid: got %b want 1", bus.o_data_valid); else pass_cnt++;
    total_cnt++; if (perr !== 1'b1) $display("FAIL par_bad_perr: got %b want 1", perr); else pass_cnt++;
    total_cnt++; if (bus.o_data !== 8'h36) $display("FAIL par_bad_data: got %h want 36", bus.o_data); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (perr !== 1'b0) $display("FAIL par_idle_perr: got %b want 0", perr); else pass_cnt++;
  endtask
`endif

  initial begin
    rst = 1'b1; prog_mode = 1'b0; prog_data = '0; prog_strobe = 1'b0; prog_load = 1'b0;
    bus.i_address = '0; bus.i_write_enable = 1'b0; bus.i_read_enable = 1'b0; bus.i_data = '0;
    test_reset();
    test_readback_all();
    test_run();
    test_readback_all();
    test_program();
    test_readback_all();
    test_strobe_through_reset();
    test_readback_all();
    test_reset_mid();
    test_readback_all();
`ifdef RAM_SYNC_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ram_sync.md
Name: ram_sync

Overview:
- Parametrised, clocked successor to the 16-byte asynchronous RAM in the SAP memory path.
- Provides synchronous bus read/write in run mode, with registered read data and a valid flag.
- Provides a manual program-loader mode: switch-entered data is written at an auto-incrementing pointer.
- Zero-fills itself after reset, and exports a drive-enable so the top level owns the W-bus tristate.

Parameters:
- DATA_WIDTH, 8, word width in bits.
- ADDR_WIDTH, 4, address width; depth = 2**ADDR_WIDTH.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_program_mode  in  1  0 = run (bus access), 1 = manual programming.
- i_program_data  in  DATA_WIDTH  programming switch value.
- i_program_strobe  in  1  debounced deposit button, level; the write is taken on its rising edge.
- i_program_load  in  1  program mode only; loads the pointer from i_address.
- i_address  in  ADDR_WIDTH  run-mode access address / pointer load value.
- i_write_enable  in  1  run-mode write of i_data at i_address.
- i_read_enable  in  1  run-mode read request.
- i_data  in  DATA_WIDTH  W-bus write data.
- o_data  out  DATA_WIDTH  registered read data.
- o_data_valid  out  1  o_data holds the response to a read accepted the previous cycle.
- o_drive  out  1  top level drives W-bus with o_data while high (equals o_data_valid).
- o_program_address  out  ADDR_WIDTH  current loader pointer.
- o_busy  out  1  clear sequence in progress; all requests ignored.
- o_parity_error  out  1  see Optional Feature.

Behaviour:
- States: CLEAR, RUN, PROGRAM. All state updates occur on the rising edge of i_clk.
- Reset, from any state and mid-operation:
  - state <= CLEAR; clear counter <= 0; pointer <= 0.
  - o_data <= 0; o_data_valid, o_drive, o_parity_error <= 0; o_busy <= 1.
  - Strobe edge-detect history <= 1, so a button held through reset does not fire.
- CLEAR:
  - Writes 0 at the clear counter each cycle and increments the counter.
  - After writing address DEPTH-1 (DEPTH cycles total), o_busy <= 0 and the state moves to PROGRAM if i_program_mode=1, else RUN.
  - All inputs are ignored while in CLEAR.
- RUN:
  - i_write_enable=1: mem[i_address] <= i_data. No read response is produced that cycle, even if i_read_enable=1 (write supersedes read).
  - i_read_enable=1 with i_write_enable=0: next cycle o_data = mem[i_address] and o_data_valid=1. Latency is exactly 1 cycle.
  - No read accepted: o_data_valid <= 0 next cycle; o_data holds its last value.
  - Back-to-back reads are permitted, one response per cycle.
  - A read one cycle after a write to the same address returns the new data.
  - i_program_mode=1 sampled: next state PROGRAM; strobe history <= current i_program_strobe.
- PROGRAM:
  - Rising edge of i_program_strobe (prev=0, now=1): mem[pointer] <= i_program_data; pointer <= pointer+1, wrapping DEPTH-1 -> 0.
  - i_program_load=1: pointer <= i_address; this has priority over a same-cycle strobe edge, and no write occurs.
  - Bus inputs are ignored; o_data_valid=0.
  - i_program_mode=0 sampled: next state RUN.
- Mode changes take effect on the cycle after they are sampled. A mode change in the same cycle as a request: the request is handled per the current state.
- o_program_address always reflects the pointer. The pointer is retained across RUN/PROGRAM switches.

Optional Feature:
- Macro RAM_SYNC_PARITY_EN.
- When defined:
  - Storage is DATA_WIDTH+1 bits per word; the extra bit holds the even parity of the written data.
  - Clear writes parity 0.
  - On each read response, o_parity_error = (^stored data) != stored parity bit; it is valid when o_data_valid=1 and 0 otherwise.
- When undefined: storage is DATA_WIDTH bits and o_parity_error is tied to 0.

Decomposition:
- Package sap_ram_pkg holds:
  - the state enum ram_state_t {CLEAR, RUN, PROGRAM};
  - localparam constants MODE_RUN=0 and MODE_PROGRAM=1.
- Sub-module sap_edge_detect: 1-bit registered rising-edge detector with synchronous reset-to-1 history. It is reused for the front-panel buttons.

Test Plan:
- Reset then idle, ADDR_WIDTH=4 -> o_busy=1 for exactly 16 cycles, then 0; reading every address returns 0x00 with o_data_valid one cycle after each request.
- RUN: write 0xA5 @3, next cycle read @3 -> o_data=0xA5, o_data_valid=1 exactly one cycle later; write+read @3 in the same cycle -> o_data_valid=0.
- PROGRAM: load pointer 14, three strobe pulses with data 0x11/0x22/0x33 -> mem[14]=0x11, mem[15]=0x22, mem[0]=0x33; o_program_address=1.
- Strobe held high across 5 cycles -> one write only; strobe high through reset -> no write after CLEAR.
- Reset asserted mid-CLEAR and mid-PROGRAM -> CLEAR restarts from 0; pointer=0; all memory reads back 0.
- RAM_SYNC_PARITY_EN: force a stored bit flip @5 via hierarchical write, read @5 -> o_parity_error=1 with o_data_valid=1; a normal read gives 0.
